ov7670_capture: RTL
===================

OV7670_CAPTURE -- requirements
Module: ov7670_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, pixels per line (x_cnt limit).
REQ-002 SHALL have parameter V_ACTIVE, default 480, lines per frame (y_cnt limit).
REQ-003 SHALL have parameter SKIP_FRAMES, default 2, frames discarded after reset (only used with SKIP_FRAMES_EN).
REQ-004 SHALL have port: sclk  input  1  sensor pixel clock; all logic on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port: vsync  input  1  sensor frame sync, high = vertical blanking.
REQ-007 SHALL have port: href  input  1  sensor line valid, high = byte on din is valid.
REQ-008 SHALL have port: din  input  8  sensor byte bus (RGB565, high byte first).
REQ-009 SHALL have port: pix_data  output  16  assembled pixel {first byte, second byte}.
REQ-010 SHALL have port: pix_valid  output  1  one-cycle strobe, pix_data valid.
REQ-011 SHALL have port: x_cnt  output  10  column index of the current pix_data.
REQ-012 SHALL have port: y_cnt  output  9  line index of the current pix_data.
REQ-013 SHALL have port: frame_start  output  1  one-cycle pulse at start of a captured frame.
REQ-014 SHALL have port: frame_end  output  1  one-cycle pulse at end of a captured frame.
REQ-015 SHALL have port: line_err  output  1  sticky flag: odd byte count or line overflow seen.

Function
REQ-016 SHALL register vsync/href/din once (stage 1); edges SHALL be detected on the registered copies against a second register.
REQ-017 SHALL implement states WAIT_SYNC, IDLE_BLANK, ACTIVE.
REQ-018 WAIT_SYNC: SHALL advance to IDLE_BLANK on the first vsync rising edge; never capture mid-frame.
REQ-019 IDLE_BLANK -> ACTIVE on vsync falling edge; frame_start SHALL pulse the same cycle the state changes; x_cnt, y_cnt SHALL clear.
REQ-020 ACTIVE: while href high, a byte-phase bit SHALL toggle every cycle; phase 0 latches high byte, phase 1 forms pix_data.
REQ-021 pix_valid SHALL assert the cycle after the registered second byte (latency 3 sclk from din of the second byte to pix_valid).
REQ-022 x_cnt SHALL equal 0 for the first pixel of a line and increment by 1 after each pix_valid.
REQ-023 On href falling edge: byte-phase SHALL clear, x_cnt SHALL clear, y_cnt SHALL increment by 1.
REQ-024 href falling with phase 1 pending (odd bytes) SHALL drop the orphan byte, set line_err, emit no pix_valid.
REQ-025 A pixel with x_cnt = H_ACTIVE, or a line with y_cnt = V_ACTIVE, SHALL be dropped (no pix_valid) and SHALL set line_err; counters SHALL saturate, not wrap.
REQ-026 ACTIVE -> IDLE_BLANK on vsync rising edge; frame_end SHALL pulse that cycle, regardless of line count.
REQ-027 vsync rising and href high in the same cycle: vsync SHALL win; the pending byte is discarded, frame_end pulses.
REQ-028 frame_start and frame_end SHALL never be asserted in the same cycle.
REQ-029 line_err SHALL clear only on reset.

Reset
REQ-030 rst high SHALL force state WAIT_SYNC, pix_data=0, pix_valid=0, x_cnt=0, y_cnt=0, frame_start=0, frame_end=0, line_err=0, skip counter=0, all sync registers=0.
REQ-031 rst asserted mid-frame SHALL abort the frame without frame_end; capture resumes only after a new vsync rising-then-falling sequence.

Configuration
REQ-032 Macro SKIP_FRAMES_EN defined: first SKIP_FRAMES frames after reset SHALL run the state machine but suppress pix_valid, frame_start, frame_end; the frame after those SHALL be captured.
REQ-033 Macro SKIP_FRAMES_EN undefined: the first complete frame after WAIT_SYNC SHALL be captured; no skip counter SHALL exist.

Verification
REQ-034 Frame 4 lines x 8 bytes, bytes 0x11,0x22,...: pix_data 0x1122 first with x_cnt=0,y_cnt=0; 16 pix_valid total; one frame_start, one frame_end.
REQ-035 Reset released while vsync low and href toggling: no pix_valid until vsync rises then falls.
REQ-036 Line of 7 bytes: 3 pix_valid, line_err=1, next line starts with x_cnt=0, y_cnt incremented.
REQ-037 H_ACTIVE=4, line of 12 bytes: exactly 4 pix_valid (x_cnt 0..3), line_err=1.
REQ-038 rst pulsed after 2 lines of a frame: outputs 0 immediately, no frame_end, next full frame captured normally.
REQ-039 SKIP_FRAMES_EN, SKIP_FRAMES=2, 3 frames sent: pix_valid/frame_start only during frame 3; without macro, during all 3.

Source files
------------

// File: rtl/ov7670_capture.sv
// OV7670 DVP capture: syncs vsync/href/din, pairs RGB565 bytes into pixels, tracks x/y.
// Optional macro SKIP_FRAMES_EN discards the first SKIP_FRAMES frames after reset.
module ov7670_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 2
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        vsync,
  input  logic        href,
  input  logic [7:0]  din,
  output logic [15:0] pix_data,
  output logic        pix_valid,
  output logic [9:0]  x_cnt,
  output logic [8:0]  y_cnt,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_err
);

  typedef enum logic [1:0] {WAIT_SYNC, IDLE_BLANK, ACTIVE} state_t;

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

  state_t      state, state_nxt;
  logic        vs1, vs2, hr1, hr2;
  logic [7:0]  d1;
  logic        vs_rise, vs_fall, href_fall;
  logic        start_evt, end_evt, byte_evt, line_evt;
  logic        pix_evt, drop_evt;
  logic        phase;
  logic [7:0]  hi_byte;
  logic        pix_pend, pix_q, eol_pend;
  logic [9:0]  x_eff;
  logic        x_full, y_full;
  logic        suppress;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      vs1 <= 1'b0;
      vs2 <= 1'b0;
      hr1 <= 1'b0;
      hr2 <= 1'b0;
      d1  <= 8'h00;
    end else begin
      vs1 <= vsync;
      hr1 <= href;
      d1  <= din;
      vs2 <= vs1;
      hr2 <= hr1;
    end
  end

  assign vs_rise   = vs1 & ~vs2;
  assign vs_fall   = ~vs1 & vs2;
  assign href_fall = ~hr1 & hr2;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= WAIT_SYNC;
    else     state <= state_nxt;
  end

  // A vsync rise in ACTIVE wins over any byte presented in the same cycle.
  always_comb begin
    state_nxt = state;
    start_evt = 1'b0;
    end_evt   = 1'b0;
    byte_evt  = 1'b0;
    line_evt  = 1'b0;
    case (state)
      WAIT_SYNC:  if (vs_rise) state_nxt = IDLE_BLANK;
      IDLE_BLANK: if (vs_fall) begin
        state_nxt = ACTIVE;
        start_evt = 1'b1;
      end
      ACTIVE: begin
        if (vs_rise) begin
          state_nxt = IDLE_BLANK;
          end_evt   = 1'b1;
        end else if (href_fall) begin
          line_evt = 1'b1;
        end else if (hr1) begin
          byte_evt = 1'b1;
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase
  end

  // x_cnt lags by the pixel still in the output stage, so count it as already taken.
  assign x_eff    = x_cnt + {9'd0, pix_q};
  assign x_full   = (x_eff >= H_LIM);
  assign y_full   = (y_cnt >= V_LIM);
  assign pix_evt  = byte_evt & phase & ~x_full & ~y_full;
  assign drop_evt = byte_evt & phase & (x_full | y_full);

`ifdef SKIP_FRAMES_EN
  localparam int SKW = $clog2(SKIP_FRAMES + 2);
  logic [SKW-1:0] skip_cnt;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst)                      skip_cnt <= '0;
    else if (end_evt && suppress) skip_cnt <= skip_cnt + 1'b1;
  end

  assign suppress = (skip_cnt < SKW'(SKIP_FRAMES));
`else
  assign suppress = 1'b0;
`endif

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      phase       <= 1'b0;
      hi_byte     <= 8'h00;
      pix_pend    <= 1'b0;
      pix_q       <= 1'b0;
      eol_pend    <= 1'b0;
      pix_data    <= 16'h0000;
      pix_valid   <= 1'b0;
      x_cnt       <= 10'd0;
      y_cnt       <= 9'd0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      pix_pend    <= 1'b0;
      pix_q       <= pix_pend;
      pix_valid   <= pix_pend & ~suppress;
      eol_pend    <= line_evt;
      frame_start <= start_evt & ~suppress;
      frame_end   <= end_evt & ~suppress;

      if (byte_evt) begin
        phase <= ~phase;
        if (!phase) hi_byte <= d1;
      end
      if (pix_evt) begin
        pix_data <= {hi_byte, d1};
        pix_pend <= 1'b1;
      end
      if (drop_evt) line_err <= 1'b1;
      if (line_evt) begin
        phase <= 1'b0;
        if (phase) line_err <= 1'b1;
      end
      if (end_evt) phase <= 1'b0;

      // Line-end bookkeeping waits one cycle so the last pixel shows its own x/y.
      if (start_evt) begin
        x_cnt <= 10'd0;
        y_cnt <= 9'd0;
      end else if (eol_pend) begin
        x_cnt <= 10'd0;
        if (y_cnt < V_LIM) y_cnt <= y_cnt + 9'd1;
      end else if (pix_q && (x_cnt < H_LIM)) begin
        x_cnt <= x_cnt + 10'd1;
      end
    end
  end

endmodule
